// File: rtl/uart_tx_if.sv
// Byte handshake between on-chip producers and the UART transmitter queue.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Buffered UART transmitter: small byte FIFO feeding an LSB-first serializer on tx232.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_tx #(
   parameter int unsigned CLK_HZ     = 48_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   uart_tx_if.slave                    tx_if,
   output logic                        tx232,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_baud, w_baud_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic          r_tx232, w_tx_nxt;
   logic          r_busy;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0] r_count, w_count_nxt;
   logic          w_push, w_pop, w_baud_end;
   logic [7:0]    w_head;
`ifdef UART_TX_PARITY_EN
   logic          r_parity, w_parity_nxt;
`endif

   // Ready comes from the registered count only, so a full queue never accepts on a pop cycle.
   assign tx_if.tx_ready = (r_count != LW'(FIFO_DEPTH));
   assign w_push         = tx_if.tx_valid && tx_if.tx_ready;
   assign w_head         = r_mem[r_rd_ptr];
   assign w_baud_end     = (r_baud == CW'(DIV - 1));

   assign tx232      = r_tx232;
   assign busy       = r_busy;
   assign fifo_level = r_count;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + LW'(1);
         2'b01:   w_count_nxt = r_count - LW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Next state; w_tx_nxt is the line level for the current state, flopped one cycle later.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_baud_end ? '0 : r_baud + CW'(1);
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt = ^w_head;
`endif
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_baud_end) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = 3'd0;
            end
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_baud_end) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_idx_nxt   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            w_tx_nxt = r_parity;
            if (w_baud_end) w_state_nxt = S_STOP;
         end
`endif
         S_STOP: begin
            if (w_baud_end) begin
               // A waiting byte starts right at the end of stop, with no idle bit.
               if (r_count != '0) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                  w_parity_nxt = ^w_head;
`endif
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_shift  <= '0;
         r_idx    <= '0;
         r_tx232  <= 1'b1;
         r_busy   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_shift  <= w_shift_nxt;
         r_idx    <= w_idx_nxt;
         r_tx232  <= w_tx_nxt;
         r_busy   <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
         r_count  <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
`ifdef UART_TX_PARITY_EN
         r_parity <= w_parity_nxt;
`endif
      end
   end

   // Queue storage needs no reset: the count decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= tx_if.tx_data;
   end
endmodule
